// File: rtl/target_hit_if.sv
// Target block bus: bullet/pixel inputs in, hit status and pixel colour out.
// Pure wiring; no latency, no backpressure.
interface target_hit_if;
    logic        update_clk;
    logic [9:0]  col;
    logic [9:0]  row;
    logic [10:0] bullet_x;
    logic [10:0] bullet_y;
    logic [3:0]  hp;
    logic [1:0]  state;
    logic        hit;
    logic        killed;
    logic [7:0]  hits_total;
    logic        is_target;
    logic [11:0] target_rgb;

    modport master (
        output update_clk, col, row, bullet_x, bullet_y,
        input  hp, state, hit, killed, hits_total, is_target, target_rgb
    );

    modport slave (
        input  update_clk, col, row, bullet_x, bullet_y,
        output hp, state, hit, killed, hits_total, is_target, target_rgb
    );
endinterface

// File: rtl/target_hit.sv
// Bullet-vs-target hit detection with hp, flash/respawn timers and pixel output.
// Tick effects land two clk edges after update_clk is first sampled high; pixel path combinational; no backpressure.
module target_hit #(
    parameter int          target_x      = 600,
    parameter int          target_y      = 400,
    parameter int          target_w      = 32,
    parameter int          target_h      = 32,
    parameter int          bullet_w      = 4,
    parameter int          bullet_h      = 4,
    parameter int          max_hp        = 5,
    parameter int          flash_ticks   = 8,
    parameter int          respawn_ticks = 120,
    parameter logic [11:0] color_alive   = 12'hF00,
    parameter logic [11:0] color_flash   = 12'hFF0
) (
    input  logic        clk,
    input  logic        rst,
    target_hit_if.slave bus
);

    typedef enum logic [1:0] {
        ALIVE = 2'b00,
        FLASH = 2'b01,
        DEAD  = 2'b10
    } state_t;

    localparam int CNT_MAX = (flash_ticks > respawn_ticks) ? flash_ticks : respawn_ticks;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] FLASH_CNT   = CNT_W'(flash_ticks);
    localparam logic [CNT_W-1:0] RESPAWN_CNT = CNT_W'(respawn_ticks);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [3:0]       HP_FULL     = 4'(max_hp);

    localparam logic signed [11:0] OV_L = 12'(target_x);
    localparam logic signed [11:0] OV_R = 12'(target_x + target_w);
    localparam logic signed [11:0] OV_T = 12'(target_y);
    localparam logic signed [11:0] OV_B = 12'(target_y + target_h);
    localparam logic signed [11:0] BW   = 12'(bullet_w);
    localparam logic signed [11:0] BH   = 12'(bullet_h);

    localparam logic [10:0] PIX_L = 11'(target_x);
    localparam logic [10:0] PIX_R = 11'(target_x + target_w);
    localparam logic [10:0] PIX_T = 11'(target_y);
    localparam logic [10:0] PIX_B = 11'(target_y + target_h);

    // update_clk is asynchronous: two flops to synchronise, a third to find the rising edge
    logic s1, s2, s3;
    logic tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.update_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign tick = s2 & ~s3;

    // Positions arrive biased by +1 so column -1 is representable; undo it in signed space
    logic signed [11:0] bl;
    logic signed [11:0] bt;
    logic               ov;

    assign bl = $signed({1'b0, bus.bullet_x}) - 12'sd1;
    assign bt = $signed({1'b0, bus.bullet_y}) - 12'sd1;
    assign ov = (bl < OV_R) && ((bl + BW) > OV_L) &&
                (bt < OV_B) && ((bt + BH) > OV_T);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       hp_q, hp_d;
    logic             prev_ov_q, prev_ov_d;
    logic [7:0]       total_q, total_d;
    logic             hit_q, hit_d;
    logic             killed_q, killed_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ALIVE;
            cnt_q     <= '0;
            hp_q      <= HP_FULL;
            prev_ov_q <= 1'b0;
            total_q   <= 8'd0;
            hit_q     <= 1'b0;
            killed_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hp_q      <= hp_d;
            prev_ov_q <= prev_ov_d;
            total_q   <= total_d;
            hit_q     <= hit_d;
            killed_q  <= killed_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hp_d      = hp_q;
        prev_ov_d = prev_ov_q;
        total_d   = total_q;
        hit_d     = 1'b0;
        killed_d  = 1'b0;

        case (state_q)
            ALIVE: begin
                // Only a fresh overlap counts, so one bullet passing through hits once
                if (tick && ov && !prev_ov_q) begin
                    hp_d  = hp_q - 4'd1;
                    hit_d = 1'b1;
                    if (total_q != 8'hFF) begin
                        total_d = total_q + 8'd1;
                    end
                    if (hp_q == 4'd1) begin
                        state_d  = DEAD;
                        cnt_d    = RESPAWN_CNT;
                        killed_d = 1'b1;
                    end else begin
                        state_d = FLASH;
                        cnt_d   = FLASH_CNT;
                    end
                end
            end
            FLASH: begin
                if (tick) begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ALIVE;
                    end
                end
            end
            DEAD: begin
                if (tick) begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ALIVE;
                        hp_d    = HP_FULL;
                    end
                end
            end
            default: begin
                state_d = ALIVE;
            end
        endcase

        if (tick) begin
            prev_ov_d = ov;
        end
    end

    logic [10:0] col_w;
    logic [10:0] row_w;
    logic        in_box;
    logic        visible;

    assign col_w   = {1'b0, bus.col};
    assign row_w   = {1'b0, bus.row};
    assign in_box  = (col_w >= PIX_L) && (col_w < PIX_R) &&
                     (row_w >= PIX_T) && (row_w < PIX_B);
    assign visible = in_box && (state_q != DEAD);

    always_comb begin
        bus.target_rgb = 12'h000;
        if (visible) begin
            bus.target_rgb = (state_q == FLASH) ? color_flash : color_alive;
        end
    end

    assign bus.is_target  = visible;
    assign bus.hp         = hp_q;
    assign bus.state      = state_q;
    assign bus.hit        = hit_q;
    assign bus.killed     = killed_q;
    assign bus.hits_total = total_q;

endmodule

// File: tb/tb_target_hit.sv
module tb_target_hit;

    localparam int TX = 600, TY = 400, TW = 32, TH = 32, BWD = 4, BHT = 4;
    localparam int MAXHP = 5, FLASHT = 8, RESPT = 120;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    target_hit_if bus();

    target_hit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: game rules in plain integers, advanced once per tick
    int m_state;   // 0 alive, 1 flash, 2 dead
    int m_hp;
    int m_left;    // ticks remaining in flash/dead
    int m_total;
    bit m_prev;
    bit e_hit, e_kill;

    int hit_count, last_hit_x;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit overlap(input int bx, input int by);
        int bl, bt;
        bl = bx - 1;
        bt = by - 1;
        return (bl < TX + TW) && (bl + BWD > TX) && (bt < TY + TH) && (bt + BHT > TY);
    endfunction

    task automatic model_reset();
        m_state = 0; m_hp = MAXHP; m_left = 0; m_total = 0; m_prev = 0;
        e_hit = 0; e_kill = 0;
    endtask

    task automatic model_tick(input int bx, input int by);
        bit o;
        o = overlap(bx, by);
        e_hit = 0;
        e_kill = 0;
        if (m_state == 0) begin
            if (o && !m_prev) begin
                e_hit = 1;
                m_hp = m_hp - 1;
                m_total = (m_total < 255) ? m_total + 1 : 255;
                if (m_hp == 0) begin
                    m_state = 2; m_left = RESPT; e_kill = 1;
                end else begin
                    m_state = 1; m_left = FLASHT;
                end
            end
        end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                if (m_state == 2) m_hp = MAXHP;
                m_state = 0;
            end
        end
        m_prev = o;
    endtask

    task automatic check_pixel(input string tag, input int c, input int r);
        bit inb, vis;
        int rgb;
        bus.col = 10'(c);
        bus.row = 10'(r);
        #1;
        inb = (c >= TX) && (c < TX + TW) && (r >= TY) && (r < TY + TH);
        vis = inb && (m_state != 2);
        rgb = !vis ? 'h000 : (m_state == 1) ? 'hFF0 : 'hF00;
        check({tag, "_is_target"}, 32'(bus.is_target), 32'(vis));
        check({tag, "_rgb"}, 32'(bus.target_rgb), 32'(rgb));
    endtask

    task automatic do_tick(input int bx, input int by);
        @(negedge clk);
        bus.bullet_x = 11'(bx);
        bus.bullet_y = 11'(by);
        bus.update_clk = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        model_tick(bx, by);
        if (bus.hit === 1'b1) begin
            hit_count++;
            last_hit_x = bx;
        end
        check("hit", 32'(bus.hit), 32'(e_hit));
        check("killed", 32'(bus.killed), 32'(e_kill));
        check("state", 32'(bus.state), 32'(m_state));
        check("hp", 32'(bus.hp), 32'(m_hp));
        check("hits_total", 32'(bus.hits_total), 32'(m_total));
        check_pixel("pix600", 600, 400);
        check_pixel("pix632", 632, 400);
        check_pixel("pixrnd", $urandom_range(585, 645), $urandom_range(385, 445));
        @(posedge clk);
        #1;
        check("hit_pulse_end", 32'(bus.hit), 32'd0);
        check("killed_pulse_end", 32'(bus.killed), 32'd0);
        @(negedge clk);
        bus.update_clk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic kill_target();
        for (int k = 0; k < 12 && m_state != 2; k++) begin
            do_tick(801, 801);
            do_tick(610, 411);
            repeat (FLASHT) do_tick(610, 411);
        end
        check("reached_dead", 32'(bus.state), 32'd2);
    endtask

    initial begin
        rst = 1'b1;
        bus.update_clk = 1'b0;
        bus.col = 10'd0;
        bus.row = 10'd0;
        bus.bullet_x = 11'd801;
        bus.bullet_y = 11'd801;
        model_reset();
        hit_count = 0;
        last_hit_x = -1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_hp", 32'(bus.hp), 32'd5);
        check("rst_total", 32'(bus.hits_total), 32'd0);
        check("rst_hit", 32'(bus.hit), 32'd0);
        check("rst_killed", 32'(bus.killed), 32'd0);

        // 1: parked bullet never hits
        repeat (10) do_tick(801, 801);
        check("park_hits", 32'(hit_count), 32'd0);

        // 2: sweep right through the target
        for (int x = 590; x <= 640; x++) do_tick(x, 411);
        check("sweep_hit_count", 32'(hit_count), 32'd1);
        check("sweep_hit_x", 32'(last_hit_x), 32'd598);

        // 3: bullet held inside through the whole flash, then re-entered
        do_tick(610, 411);
        repeat (FLASHT) do_tick(610, 411);
        check("flash_expired_state", 32'(bus.state), 32'd0);
        do_tick(801, 801);
        do_tick(610, 411);
        check("reentry_hp", 32'(bus.hp), 32'd2);
        repeat (FLASHT) do_tick(801, 801);

        // 4: drain hp, then random traffic while dead
        kill_target();
        for (int k = 0; k < RESPT + 5 && m_state == 2; k++)
            do_tick($urandom_range(585, 640), $urandom_range(395, 435));
        check("respawn_state", 32'(bus.state), 32'd0);
        check("respawn_hp", 32'(bus.hp), 32'd5);
        check("respawn_total", 32'(bus.hits_total), 32'd5);

        // Random walk including the column -1 and parked corners
        for (int k = 0; k < 40; k++) begin
            int sel;
            sel = $urandom_range(0, 7);
            if (sel == 0) do_tick(801, 801);
            else if (sel == 1) do_tick(0, $urandom_range(395, 435));
            else do_tick($urandom_range(590, 640), $urandom_range(393, 435));
        end

        // 6: reset during DEAD on the same edge a tick would register
        if (m_state != 2) kill_target();
        repeat (3) do_tick(801, 801);
        @(negedge clk);
        bus.update_clk = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.update_clk = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        check("rst_dead_state", 32'(bus.state), 32'd0);
        check("rst_dead_hp", 32'(bus.hp), 32'd5);
        check("rst_dead_total", 32'(bus.hits_total), 32'd0);
        check("rst_dead_hit", 32'(bus.hit), 32'd0);
        check("rst_dead_killed", 32'(bus.killed), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_state", 32'(bus.state), 32'd0);
        check("post_rst_hit", 32'(bus.hit), 32'd0);
        check("post_rst_hp", 32'(bus.hp), 32'd5);
        do_tick(610, 411);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/target_hit.md
Name: target_hit

Overview:
- Consumes the bullet position stream (bullet_x/bullet_y, each pixel position + 1) and decides when a bullet strikes a fixed rectangular target, such as a boss or save point.
- Tracks target hit points through an ALIVE/FLASH/DEAD state machine with invulnerability and respawn timers.
- Emits hit/kill pulses for game logic.
- Emits per-pixel is_target/target_rgb for the VGA compositor, in the same style as the sprite blocks.

Parameters:
target_x, 600, left pixel column of target box
target_y, 400, top pixel row of target box
target_w, 32, target width in pixels
target_h, 32, target height in pixels
bullet_w, 4, bullet width in pixels
bullet_h, 4, bullet height in pixels
max_hp, 5, hit points at reset/respawn (1..15)
flash_ticks, 8, invulnerable ticks after a non-fatal hit (>=1)
respawn_ticks, 120, ticks spent DEAD before respawn (>=1)
color_alive, 12'hF00, target colour in ALIVE
color_flash, 12'hFF0, target colour in FLASH

Ports:
clk  in  1  system clock; all state is clocked on its rising edge
rst  in  1  synchronous active-high reset
update_clk  in  1  game-update strobe, a slow level signal asynchronous to clk; one rising edge = one tick
col  in  10  current VGA pixel column
row  in  10  current VGA pixel row
bullet_x  in  11  bullet left column + 1 (0 means column -1; >=801 means parked offscreen)
bullet_y  in  11  bullet top row + 1
hp  out  4  current hit points
state  out  2  00 ALIVE, 01 FLASH, 10 DEAD
hit  out  1  one-clk pulse when a hit is accepted
killed  out  1  one-clk pulse when hp reaches 0
hits_total  out  8  accepted-hit count, saturates at 255
is_target  out  1  current pixel belongs to the visible target
target_rgb  out  12  target colour for the current pixel

Behaviour:
- Tick generation: three flops s1<=update_clk, s2<=s1, s3<=s2; tick = s2 & ~s3.
  - If update_clk is first sampled high at clk edge N, tick is high in the cycle after edge N+1.
  - All tick effects register at edge N+2.
  - hit and killed are high for exactly the one cycle after edge N+2.
- Overlap (combinational, 12-bit signed):
  - bl = bullet_x - 1, bt = bullet_y - 1.
  - ov = (bl < target_x+target_w) && (bl+bullet_w > target_x) && (bt < target_y+target_h) && (bt+bullet_h > target_y).
  - No unsigned wrap is allowed; bullet_x = 0 gives bl = -1.
- prev_ov register: updated to ov on every tick in every state. A hit needs ov=1 and prev_ov=0 on the same tick, so one bullet passing through counts once.
- ALIVE, on tick with ov & ~prev_ov:
  - hp <= hp-1; hit <= 1; hits_total increments (saturating at 255).
  - If the old hp was 1: go to DEAD, load cnt <= respawn_ticks, killed <= 1.
  - Otherwise: go to FLASH, load cnt <= flash_ticks.
- FLASH:
  - Every tick: cnt <= cnt-1; overlaps are ignored.
  - On the tick where cnt==1: go to ALIVE.
  - A bullet still overlapping on re-entry to ALIVE does not hit, because prev_ov=1.
- DEAD:
  - Every tick: cnt <= cnt-1; overlaps are ignored; hp stays 0.
  - On the tick where cnt==1: go to ALIVE with hp <= max_hp. hits_total is not cleared.
- No tick means no state, counter, hp or prev_ov change.
- Pixel output (combinational):
  - in_box = col in [target_x, target_x+target_w) and row in [target_y, target_y+target_h).
  - is_target = in_box && state != DEAD.
  - target_rgb = color_flash in FLASH, color_alive in ALIVE, 12'h000 when is_target=0.
- Reset values: state ALIVE, hp max_hp, cnt 0, prev_ov 0, hits_total 0, s1..s3 0, hit 0, killed 0.
- Reset mid-FLASH or mid-DEAD aborts the timer immediately.
- rst overrides a coincident tick.
- The state encoding 11 is illegal and recovers to ALIVE on the next clk.

Test Plan:
1. Reset, then bullet_x=bullet_y=801 for 10 ticks -> hp=5, state=00, hit never asserted, hits_total=0.
2. Bullet moves right by 1 per tick at bullet_y=411 from bullet_x=590 -> exactly one hit, on the tick with bullet_x=598 (bl=597, bl+4=601 > 600); state goes to 01, hp=4; while the bullet continues through, no further hit.
3. After a hit, keep the bullet at bullet_x=610, bullet_y=411 -> FLASH lasts 8 ticks; state returns to 00 with no new hit; moving the bullet to 801 for one tick and back gives hit, hp=3.
4. Five separate entries (each followed by exit, flash expiry and re-entry) -> the fifth gives hit and killed in the same cycle, state=10, hp=0; after 120 ticks state=00, hp=5, hits_total=5.
5. Check the pixel at col=600,row=400 and col=632,row=400 in ALIVE/FLASH/DEAD -> is_target 1/1/0 at 600 and always 0 at 632; target_rgb F00/FF0/000 at 600.
6. Assert rst for one clk mid-DEAD, coincident with a tick edge -> next cycle state=00, hp=5, hits_total=0, no hit or killed pulse.
